spi_slave_if: RTL and testbench

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

---
 rtl/spi_slave_if.sv | 149 ++++++++++++++
 tb/tb_spi_slave_if.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises command/address/data frames from MOSI
// and serialises one read byte onto MISO for read-data frames.
// Optional feature: define SPI_ABORT_FLAG_EN to add the frame_err output,
// a one-cycle pulse when SS_n rises before a frame has completed.
//
// Handshakes: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure. tx_valid qualifies tx_data and may stay high indefinitely;
// tx_data is captured exactly once per read-data frame, on the first cycle
// after the frame completes in which tx_valid is high.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MOSI,
  input  logic                 SS_n,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef SPI_ABORT_FLAG_EN
  output logic                 frame_err,
`endif
  output logic [2:0]           state_dbg
);

  localparam int CW = $clog2(ADDR_SIZE + 2);
  localparam logic [CW-1:0] LAST_RX = CW'(ADDR_SIZE);
  localparam logic [CW-1:0] LAST_TX = CW'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Progress inside a shifting state: receiving, waiting for the read byte,
  // sending the read byte, or finished and waiting for SS_n to rise.
  typedef enum logic [1:0] {
    PH_SHIFT   = 2'd0,
    PH_WAIT_TX = 2'd1,
    PH_TX      = 2'd2,
    PH_HOLD    = 2'd3
  } phase_t;

  state_t               state, state_nxt;
  phase_t               phase;
  logic [CW-1:0]        cnt;
  logic [ADDR_SIZE:0]   shift;
  logic [ADDR_SIZE-1:0] tx_byte;
  logic                 rd_addr_seen;
  logic                 busy;

  assign state_dbg = state;
  assign busy      = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; SS_n high aborts any active frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: receive shift register, bit counter, read-byte shifter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase        <= PH_SHIFT;
      cnt          <= '0;
      shift        <= '0;
      tx_byte      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE || SS_n) begin
        // Idle or aborting: clear frame progress, keep rd_addr_seen.
        phase <= PH_SHIFT;
        cnt   <= '0;
        MISO  <= 1'b0;
      end else if (state == CHK_CMD) begin
        shift <= {{ADDR_SIZE{1'b0}}, MOSI};
        cnt   <= '0;
      end else begin
        case (phase)
          PH_SHIFT: begin
            shift <= {shift[ADDR_SIZE-1:0], MOSI};
            if (cnt == LAST_RX) begin
              rx_data  <= {shift, MOSI};
              rx_valid <= 1'b1;
              if (shift[ADDR_SIZE:ADDR_SIZE-1] == 2'b10) rd_addr_seen <= 1'b1;
              if (shift[ADDR_SIZE:ADDR_SIZE-1] == 2'b11) rd_addr_seen <= 1'b0;
              phase <= (state == READ_DATA) ? PH_WAIT_TX : PH_HOLD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PH_WAIT_TX: begin
            if (tx_valid) begin
              tx_byte <= tx_data;
              MISO    <= tx_data[ADDR_SIZE-1];
              cnt     <= '0;
              phase   <= PH_TX;
            end
          end
          PH_TX: begin
            if (cnt == LAST_TX) begin
              MISO  <= 1'b0;
              phase <= PH_HOLD;
            end else begin
              MISO    <= tx_byte[ADDR_SIZE-2];
              tx_byte <= tx_byte << 1;
              cnt     <= cnt + CW'(1);
            end
          end
          default: MISO <= 1'b0;
        endcase
      end
    end
  end

`ifdef SPI_ABORT_FLAG_EN
  // Flag SS_n rising while a frame (including the read byte) is unfinished.
  always_ff @(posedge clk) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= SS_n && ((state == CHK_CMD) || (busy && phase != PH_HOLD));
  end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed testbench for spi_slave_if (ADDR_SIZE = 8, 10-bit frames).
module tb_spi_slave_if;

  localparam int AW = 8;
  localparam int FW = AW + 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          MOSI;
  logic          SS_n;
  logic          MISO;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic [AW-1:0] tx_data;
  logic          tx_valid;
  logic [2:0]    state_dbg;
`ifdef SPI_ABORT_FLAG_EN
  logic          frame_err;
  int            err_pulses = 0;
`endif

  int checks = 0;
  int errors = 0;
  int rx_pulses = 0;
  int exp_pulses = 0;

  spi_slave_if #(.ADDR_SIZE(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
`ifdef SPI_ABORT_FLAG_EN
    .frame_err(frame_err),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Count strobes between edges so extra or missing pulses are visible.
  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
`ifdef SPI_ABORT_FLAG_EN
    if (frame_err) err_pulses++;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select the slave and shift a full frame MSB first; returns 1 cycle after last bit.
  task automatic send_frame(input logic [FW-1:0] f);
    SS_n = 1'b0;
    tick();
    for (int i = FW - 1; i >= 0; i--) begin
      MOSI = f[i];
      tick();
      check_eq("miso_idle_rx", {31'd0, MISO}, 32'd0);
    end
  endtask

  task automatic check_rx(input string tag, input logic [FW-1:0] f, input logic [2:0] st);
    exp_pulses++;
    check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check_eq({tag, "_data"}, {22'd0, rx_data}, {22'd0, f});
    check_eq({tag, "_state"}, {29'd0, state_dbg}, {29'd0, st});
    check_eq({tag, "_pulses"}, rx_pulses + 1, exp_pulses);
  endtask

  task automatic end_frame(input string tag);
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    check_eq({tag, "_idle"}, {29'd0, state_dbg}, {29'd0, S_IDLE});
`ifdef SPI_ABORT_FLAG_EN
    check_eq({tag, "_no_ferr"}, {31'd0, frame_err}, 32'd0);
`endif
  endtask

  logic [AW-1:0] rd_byte;
  logic [5:0]    junk;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    rd_byte = 8'hC3;
    junk    = 6'b101101;

    // Reset values.
    repeat (3) tick();
    check_eq("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check_eq("rst_rx_data", {22'd0, rx_data}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_miso", {31'd0, MISO}, 32'd0);
`ifdef SPI_ABORT_FLAG_EN
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Write-address frame, then trailing bits that must be ignored.
    send_frame(10'h0A5);
    check_rx("wr_addr", 10'h0A5, S_WRITE);
    tick();
    check_eq("wr_addr_pulse_end", {31'd0, rx_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      MOSI = junk[i];
      tick();
    end
    check_eq("extra_bits_data", {22'd0, rx_data}, 32'h0A5);
    check_eq("extra_bits_pulses", rx_pulses, exp_pulses);
    check_eq("extra_bits_state", {29'd0, state_dbg}, {29'd0, S_WRITE});
    end_frame("wr_addr");

    // Write-data frame; rd_addr_seen stays clear so a 1-prefix goes to READ_ADD.
    send_frame(10'h13C);
    check_rx("wr_data", 10'h13C, S_WRITE);
    end_frame("wr_data");
    send_frame(10'h207);
    check_rx("rd_addr", 10'h207, S_READ_ADD);
    end_frame("rd_addr");

    // Read-data frame with tx_valid already high and held for 20 cycles.
    tx_data  = rd_byte;
    tx_valid = 1'b1;
    send_frame(10'h355);
    check_rx("rd_data", 10'h355, S_READ_DATA);
    check_eq("rd_data_miso_pre", {31'd0, MISO}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq($sformatf("rd_miso_%0d", k), {31'd0, MISO},
               (k < AW) ? {31'd0, rd_byte[AW-1-k]} : 32'd0);
    end
    end_frame("rd_data");
    tx_valid = 1'b0;

    // rd_addr_seen was cleared by the 11 frame: next 1-prefix is a read address.
    send_frame(10'h2F0);
    check_rx("rd_addr2", 10'h2F0, S_READ_ADD);
    end_frame("rd_addr2");

    // Abort after 5 bits: no strobe, IDLE next cycle, rd_addr_seen kept.
    SS_n = 1'b0;
    tick();
    for (int i = FW - 1; i >= FW - 5; i--) begin
      MOSI = 1'b1;
      tick();
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    check_eq("abort_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check_eq("abort_no_valid", {31'd0, rx_valid}, 32'd0);
`ifdef SPI_ABORT_FLAG_EN
    check_eq("abort_ferr", {31'd0, frame_err}, 32'd1);
`endif
    tick();
    check_eq("abort_pulses", rx_pulses, exp_pulses);
`ifdef SPI_ABORT_FLAG_EN
    check_eq("abort_ferr_end", {31'd0, frame_err}, 32'd0);
    check_eq("abort_ferr_count", err_pulses, 32'd1);
`endif

    // rd_addr_seen survived the abort: 1-prefix goes to READ_DATA; reset mid-shift.
    tx_valid = 1'b1;
    send_frame(10'h3AB);
    check_rx("rd_data2", 10'h3AB, S_READ_DATA);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("rd2_miso_%0d", k), {31'd0, MISO}, {31'd0, rd_byte[AW-1-k]});
    end
    rst_n = 1'b0;
    tick();
    check_eq("rst_mid_miso", {31'd0, MISO}, 32'd0);
    check_eq("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_mid_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
`ifdef SPI_ABORT_FLAG_EN
    check_eq("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
`endif
    tx_valid = 1'b0;
    SS_n     = 1'b1;
    rst_n    = 1'b1;
    tick();
    check_eq("rst_mid_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});

    // rd_addr_seen cleared by reset: 1-prefix frame is a read address again.
    send_frame(10'h2F0);
    check_rx("post_rst", 10'h2F0, S_READ_ADD);
    end_frame("post_rst");
    tick();
    check_eq("total_pulses", rx_pulses, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
